spmv_csr_fetch: RTL and testbench

Upstream operand feeder for the SpMV core. Walks the CSR nonzero list: reads value[k] and col_idx[k], then vector[col_idx[k]]. Presents one (vector, value) operand pair plus the 1-based nonzero index on a fixed slot cadence matching the core's 4-state MUL/REG_READ/ADD/REG_WRITE loop. Prefetches element k+1 while element k is held, so the core never starves.

---
 rtl/spmv_csr_fetch_if.sv | 25 ++
 rtl/spmv_csr_fetch.sv | 150 +++++++++++++++
 tb/tb_spmv_csr_fetch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_csr_fetch_if.sv
// Memory-side read bus of the SpMV CSR operand fetcher: value/col_idx port plus vector port.
// The fetcher drives the master modport; the backing memories sit on the slave modport.
interface spmv_csr_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int VEC_AW = 4
);
  logic              o_val_ren;
  logic [ADDR_W-1:0] o_val_addr;
  logic [DATA_W-1:0] i_val_rdata;
  logic [VEC_AW-1:0] i_col_rdata;
  logic              o_vec_ren;
  logic [VEC_AW-1:0] o_vec_addr;
  logic [DATA_W-1:0] i_vec_rdata;

  modport master (
    output o_val_ren, o_val_addr, o_vec_ren, o_vec_addr,
    input  i_val_rdata, i_col_rdata, i_vec_rdata
  );

  modport slave (
    input  o_val_ren, o_val_addr, o_vec_ren, o_vec_addr,
    output i_val_rdata, i_col_rdata, i_vec_rdata
  );
endinterface

// File: rtl/spmv_csr_fetch.sv
// CSR nonzero walker: fetches value/col_idx then vector[col], presenting one operand pair per slot.
// Optional cycle counter output o_cycle_cnt is enabled by defining SPMV_FETCH_PERF_EN.
module spmv_csr_fetch #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int VEC_AW      = 4,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [7:0]          i_nnz,
  spmv_csr_fetch_if.master    mem,
  output logic                o_core_start,
  output logic [DATA_W-1:0]   o_data_A,
  output logic [DATA_W-1:0]   o_data_B,
  output logic [7:0]          o_count,
  output logic                o_busy,
  output logic                o_done
`ifdef SPMV_FETCH_PERF_EN
  ,
  output logic [15:0]         o_cycle_cnt
`endif
);

  // Phase counter is shared by PRIME (fixed 4 cycles) and RUN (SLOT_CYCLES cycles).
  localparam int PW = (SLOT_CYCLES > 4) ? $clog2(SLOT_CYCLES) : 2;
  localparam logic [PW-1:0] SLOT_LAST  = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(3);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     phase;
  logic [7:0]        nnz_q;
  logic [7:0]        count_nx;
  logic [ADDR_W-1:0] fetch_idx;
  logic [VEC_AW-1:0] vec_addr_q;
  logic [DATA_W-1:0] stg_val, stg_vec;
  logic              core_start_q;
  logic              accept, more, slot_end, f0, f1, f2, present;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_start) state_nx = (i_nnz == 8'd0) ? S_DONE : S_PRIME;
      S_PRIME: if (phase == PRIME_LAST) state_nx = S_RUN;
      S_RUN:   if (slot_end && !more) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / strobe decode
  // NOTE: every strobe gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    accept   = 1'b0;
    f0       = 1'b0;
    f1       = 1'b0;
    f2       = 1'b0;
    present  = 1'b0;
    slot_end = 1'b0;
    more     = (o_count < nnz_q);
    unique case (state)
      S_IDLE:  accept = i_start;
      S_PRIME: begin
        f0      = (phase == PW'(0));
        f1      = (phase == PW'(1));
        f2      = (phase == PW'(2));
        present = (phase == PRIME_LAST);
      end
      S_RUN: begin
        slot_end = (phase == SLOT_LAST);
        f0       = more && (phase == PW'(0));
        f1       = more && (phase == PW'(1));
        f2       = more && (phase == PW'(2));
        present  = more && slot_end;
      end
      default: ;
    endcase
  end

  assign count_nx       = o_count + 8'd1;
  assign o_busy         = (state != S_IDLE);
  assign o_done         = (state == S_DONE);
  assign o_core_start   = core_start_q;
  assign mem.o_val_ren  = f0;
  assign mem.o_val_addr = fetch_idx;
  assign mem.o_vec_ren  = f1;
  // col_idx arrives in the F1 cycle itself, so it is forwarded straight to the vector port.
  assign mem.o_vec_addr = f1 ? mem.i_col_rdata : vec_addr_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase        <= '0;
      nnz_q        <= '0;
      fetch_idx    <= '0;
      vec_addr_q   <= '0;
      stg_val      <= '0;
      stg_vec      <= '0;
      core_start_q <= 1'b0;
      o_data_A     <= '0;
      o_data_B     <= '0;
      o_count      <= '0;
    end else begin
      core_start_q <= (state == S_PRIME) && present;
      if (accept) begin
        nnz_q     <= i_nnz;
        o_count   <= '0;
        fetch_idx <= '0;
        phase     <= '0;
      end else if (state == S_PRIME) begin
        phase <= (phase == PRIME_LAST) ? '0 : phase + PW'(1);
      end else if (state == S_RUN) begin
        phase <= slot_end ? '0 : phase + PW'(1);
      end

      if (f1) begin
        stg_val    <= mem.i_val_rdata;
        vec_addr_q <= mem.i_col_rdata;
      end
      if (f2) stg_vec <= mem.i_vec_rdata;

      if (present) begin
        // With SLOT_CYCLES=3 the prefetch F2 lands on the hand-over edge; bypass the staging reg.
        o_data_A <= f2 ? mem.i_vec_rdata : stg_vec;
        o_data_B <= stg_val;
        o_count  <= count_nx;
        if (count_nx < nnz_q) fetch_idx <= ADDR_W'(count_nx);
      end
    end
  end

`ifdef SPMV_FETCH_PERF_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                                 o_cycle_cnt <= '0;
    else if (accept)                             o_cycle_cnt <= '0;
    else if (o_busy && o_cycle_cnt != 16'hFFFF)  o_cycle_cnt <= o_cycle_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spmv_csr_fetch.sv
// Self-checking bench for spmv_csr_fetch: SLOT_CYCLES=4 and SLOT_CYCLES=3 instances against a
// per-cycle schedule model derived from the CSR walk (prime 4 cycles, then nnz slots, then DONE).
module tb_spmv_csr_fetch;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int VEC_AW = 4;

  typedef struct packed {
    logic        cs;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  cnt;
    logic        busy;
    logic        done;
    logic        vren;
    logic [7:0]  vaddr;
    logic        qren;
    logic [3:0]  qaddr;
  } obs_t;

  logic i_clk = 1'b0;
  logic i_rstn;
  logic start4, start3;
  logic [7:0] nnz_in;

  logic        cs4, cs3, busy4, busy3, done4, done3;
  logic [15:0] a4, b4, a3, b3;
  logic [7:0]  cnt4, cnt3;
`ifdef SPMV_FETCH_PERF_EN
  logic [15:0] cyc4, cyc3;
`endif

  logic [15:0] val_mem [256];
  logic [3:0]  col_mem [256];
  logic [15:0] vec_mem [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  spmv_csr_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_AW(VEC_AW)) m4 ();
  spmv_csr_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_AW(VEC_AW)) m3 ();

  spmv_csr_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_AW(VEC_AW), .SLOT_CYCLES(4)) dut4 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(start4), .i_nnz(nnz_in), .mem(m4),
    .o_core_start(cs4), .o_data_A(a4), .o_data_B(b4), .o_count(cnt4),
    .o_busy(busy4), .o_done(done4)
`ifdef SPMV_FETCH_PERF_EN
    , .o_cycle_cnt(cyc4)
`endif
  );

  spmv_csr_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_AW(VEC_AW), .SLOT_CYCLES(3)) dut3 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(start3), .i_nnz(nnz_in), .mem(m3),
    .o_core_start(cs3), .o_data_A(a3), .o_data_B(b3), .o_count(cnt3),
    .o_busy(busy3), .o_done(done3)
`ifdef SPMV_FETCH_PERF_EN
    , .o_cycle_cnt(cyc3)
`endif
  );

  // Synchronous-read memories, one port set per instance
  always @(posedge i_clk) begin
    if (m4.o_val_ren) begin
      m4.i_val_rdata <= val_mem[m4.o_val_addr];
      m4.i_col_rdata <= col_mem[m4.o_val_addr];
    end
    if (m4.o_vec_ren) m4.i_vec_rdata <= vec_mem[m4.o_vec_addr];
    if (m3.o_val_ren) begin
      m3.i_val_rdata <= val_mem[m3.o_val_addr];
      m3.i_col_rdata <= col_mem[m3.o_val_addr];
    end
    if (m3.o_vec_ren) m3.i_vec_rdata <= vec_mem[m3.o_vec_addr];
  end

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) o = '{cs4, a4, b4, cnt4, busy4, done4, m4.o_val_ren, m4.o_val_addr, m4.o_vec_ren, m4.o_vec_addr};
    else          o = '{cs3, a3, b3, cnt3, busy3, done3, m3.o_val_ren, m3.o_val_addr, m3.o_vec_ren, m3.o_vec_addr};
    return o;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start4 = v;
    else          start3 = v;
  endtask

  // One full pass on instance sel; rs0/rs1 are cycle indices at which a stray i_start is pulsed.
  task automatic run_pass(input string name, input int sel, input int nnz, input int slot,
                          input bit preset, input int rs0, input int rs1);
    logic [15:0] ea[$];
    logic [15:0] eb[$];
    int addrs[$];
    int qren_cnt = 0;
    int end_i;
    int exp_cnt;
    int j;
    obs_t o;
    if (!preset) begin
      for (int k = 0; k < nnz; k++) begin
        val_mem[k] = 16'($urandom);
        col_mem[k] = 4'($urandom_range(0, 15));
      end
      for (int v = 0; v < 16; v++) vec_mem[v] = 16'($urandom);
    end
    for (int k = 0; k < nnz; k++) begin
      ea.push_back(vec_mem[col_mem[k]]);
      eb.push_back(val_mem[k]);
    end
    end_i = (nnz == 0) ? 0 : 4 + nnz * slot;

    @(negedge i_clk);
    nnz_in = 8'(nnz);
    set_start(sel, 1'b1);
    @(negedge i_clk);
    set_start(sel, 1'b0);

    for (int i = 0; i <= end_i + 2; i++) begin
      o = observe(sel);
      if (o.vren) addrs.push_back(int'(o.vaddr));
      if (o.qren) qren_cnt++;

      vectors++;
      if (o.busy !== (i <= end_i)) begin
        miscompares++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, i, o.busy, (i <= end_i));
      end
      vectors++;
      if (o.done !== (i == end_i)) begin
        miscompares++;
        $display("FAIL %s done cyc=%0d got=%b exp=%b", name, i, o.done, (i == end_i));
      end
      vectors++;
      if (o.cs !== (nnz > 0 && i == 4)) begin
        miscompares++;
        $display("FAIL %s core_start cyc=%0d got=%b exp=%b", name, i, o.cs, (nnz > 0 && i == 4));
      end

      if (nnz == 0 || i < 4) exp_cnt = 0;
      else if (i < end_i)    exp_cnt = (i - 4) / slot + 1;
      else                   exp_cnt = nnz;
      vectors++;
      if (o.cnt !== 8'(exp_cnt)) begin
        miscompares++;
        $display("FAIL %s count cyc=%0d got=%0d exp=%0d", name, i, o.cnt, exp_cnt);
      end

      if (nnz > 0 && i >= 4) begin
        j = (i < end_i) ? (i - 4) / slot : nnz - 1;
        vectors++;
        if (o.a !== ea[j] || o.b !== eb[j]) begin
          miscompares++;
          $display("FAIL %s pair cyc=%0d got=(%h,%h) exp=(%h,%h)", name, i, o.a, o.b, ea[j], eb[j]);
        end
      end

      if (i == rs0 || i == rs1) begin
        nnz_in = 8'($urandom_range(1, 40));
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      @(negedge i_clk);
    end
    set_start(sel, 1'b0);

    vectors++;
    if (addrs.size() != nnz || qren_cnt != nnz) begin
      miscompares++;
      $display("FAIL %s fetch_count val_ren=%0d vec_ren=%0d exp=%0d", name, addrs.size(), qren_cnt, nnz);
    end else begin
      for (int k = 0; k < nnz; k++) begin
        vectors++;
        if (addrs[k] != k) begin
          miscompares++;
          $display("FAIL %s val_addr idx=%0d got=%0d exp=%0d", name, k, addrs[k], k);
        end
      end
    end

`ifdef SPMV_FETCH_PERF_EN
    vectors++;
    if (((sel == 0) ? cyc4 : cyc3) !== 16'(end_i + 1)) begin
      miscompares++;
      $display("FAIL %s cycle_cnt got=%0d exp=%0d", name, (sel == 0) ? cyc4 : cyc3, end_i + 1);
    end
`endif
  endtask

  task automatic test_reset();
    obs_t o;
    for (int s = 0; s < 2; s++) begin
      o = observe(s);
      vectors++;
      if (o !== '0) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d got=%h exp=0", s, o);
      end
    end
  endtask

  task automatic test_basic();
    val_mem[0] = 16'h3C00; val_mem[1] = 16'h4000; val_mem[2] = 16'h4200;
    col_mem[0] = 4'd2;     col_mem[1] = 4'd0;     col_mem[2] = 4'd5;
    vec_mem[2] = 16'h3C00; vec_mem[0] = 16'h4400; vec_mem[5] = 16'h3800;
    run_pass("basic", 0, 3, 4, 1'b1, -1, -1);
  endtask

  task automatic test_zero();
    run_pass("nnz0", 0, 0, 4, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) run_pass("random", 0, $urandom_range(1, 20), 4, 1'b0, -1, -1);
  endtask

  task automatic test_restart();
    // Stray starts mid-pass and on the DONE cycle (index 20 for nnz=4)
    run_pass("restart", 0, 4, 4, 1'b0, 9, 20);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    for (int k = 0; k < 5; k++) begin
      val_mem[k] = 16'($urandom);
      col_mem[k] = 4'($urandom_range(0, 15));
    end
    @(negedge i_clk);
    nnz_in = 8'd5;
    start4 = 1'b1;
    @(negedge i_clk);
    start4 = 1'b0;
    repeat (10) @(negedge i_clk);
    o = observe(0);
    vectors++;
    if (o.cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL reset_mid precount got=%0d exp=2", o.cnt);
    end
    i_rstn = 1'b0;
    #1;
    o = observe(0);
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid async_clear got=%h exp=0", o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (i == 2) i_rstn = 1'b1;
      o = observe(0);
      vectors++;
      if (o.done !== 1'b0 || o.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid no_done cyc=%0d got=%b%b exp=00", i, o.done, o.busy);
      end
    end
    run_pass("after_reset", 0, 5, 4, 1'b0, -1, -1);
  endtask

  task automatic test_long();
    run_pass("nnz16", 0, 16, 4, 1'b0, -1, -1);
  endtask

  task automatic test_slot3();
    run_pass("slot3", 1, 2, 3, 1'b0, -1, -1);
    run_pass("slot3_rand", 1, $urandom_range(3, 12), 3, 1'b0, -1, -1);
    run_pass("slot3_max", 1, 255, 3, 1'b0, -1, -1);
  endtask

  initial begin
    i_rstn = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    nnz_in = 8'd0;
    #1;
    test_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    test_basic();
    test_zero();
    test_random();
    test_restart();
    test_reset_mid();
    test_long();
    test_slot3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
